// File: rtl/adsr_envelope_pkg.sv
// Shared types and constants for the ADSR envelope slice.
// Level is unsigned 24-bit: 0 is silence, ENV_MAX is full scale.
package synth_pkg;

    localparam int ENV_WIDTH = 24;
    localparam logic [ENV_WIDTH-1:0] ENV_MAX = 24'hFFFFFF;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        DECAY,
        SUSTAIN,
        RELEASE
    } adsr_state_t;

endpackage

// File: rtl/adsr_envelope_if.sv
// Valid/ready stream bundle carrying 24-bit signed samples.
// The master drives data/valid and the slave drives ready.
interface Axis_If;
    import synth_pkg::*;

    logic [ENV_WIDTH-1:0] data;
    logic                 valid;
    logic                 ready;

    modport Master (
        output data,
        output valid,
        input  ready
    );

    modport Slave (
        input  data,
        input  valid,
        output ready
    );

endinterface

// File: rtl/adsr_envelope_level.sv
// ADSR state machine and level arithmetic, advanced once per accepted beat.
// ADSR_RETRIGGER_LEGATO_EN: keep the current level on RELEASE -> ATTACK.
module adsr_level
    import synth_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 beat,
    input  logic                 gate,
    input  logic [ENV_WIDTH-1:0] attack_step,
    input  logic [ENV_WIDTH-1:0] decay_step,
    input  logic [ENV_WIDTH-1:0] sustain_level,
    input  logic [ENV_WIDTH-1:0] release_step,
    output logic [ENV_WIDTH-1:0] level,
    output adsr_state_t          state,
    output logic                 env_active
);

    logic [ENV_WIDTH:0]   att_sum;
    logic [ENV_WIDTH-1:0] dec_room;

    // 25-bit sum so an overshoot past full scale is visible.
    assign att_sum  = {1'b0, level} + {1'b0, attack_step};
    // Distance to the sustain floor; only meaningful when level > sustain.
    assign dec_room = level - sustain_level;

    // Envelope FSM: gate is checked before any step update on each beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            level      <= '0;
            env_active <= 1'b0;
        end else if (beat) begin
            unique case (state)
                IDLE: begin
                    level <= '0;
                    if (gate) begin
                        state      <= ATTACK;
                        env_active <= 1'b1;
                    end
                end
                ATTACK: begin
                    if (!gate) begin
                        state <= RELEASE;
                    end else if (att_sum >= {1'b0, ENV_MAX}) begin
                        level <= ENV_MAX;
                        state <= DECAY;
                    end else begin
                        level <= att_sum[ENV_WIDTH-1:0];
                    end
                end
                DECAY: begin
                    if (!gate) begin
                        state <= RELEASE;
                    end else if (sustain_level >= level ||
                                 decay_step >= dec_room) begin
                        level <= sustain_level;
                        state <= SUSTAIN;
                    end else begin
                        level <= level - decay_step;
                    end
                end
                SUSTAIN: begin
                    if (!gate) begin
                        state <= RELEASE;
                    end else begin
                        level <= sustain_level;
                    end
                end
                RELEASE: begin
                    if (gate) begin
                        state <= ATTACK;
`ifndef ADSR_RETRIGGER_LEGATO_EN
                        level <= '0;
`endif
                    end else if (release_step >= level) begin
                        level      <= '0;
                        state      <= IDLE;
                        env_active <= 1'b0;
                    end else begin
                        level <= level - release_step;
                    end
                end
                default: begin
                    state      <= IDLE;
                    level      <= '0;
                    env_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/adsr_envelope.sv
// Two-stage stream pipeline scaling signed samples by the ADSR level.
// ADSR_RETRIGGER_LEGATO_EN selects legato retrigger inside adsr_level.
module adsr_envelope
    import synth_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 gate,
    input  logic [ENV_WIDTH-1:0] attack_step,
    input  logic [ENV_WIDTH-1:0] decay_step,
    input  logic [ENV_WIDTH-1:0] sustain_level,
    input  logic [ENV_WIDTH-1:0] release_step,
    Axis_If.Slave                data_in,
    Axis_If.Master               data_out,
    output logic                 env_active
);

    logic                 en;
    logic                 beat;
    logic [ENV_WIDTH-1:0] level;
    adsr_state_t          state;

    logic                 s1_valid;
    logic [ENV_WIDTH-1:0] s1_sample;
    logic [ENV_WIDTH-1:0] s1_level;

    logic                 out_valid;
    logic [ENV_WIDTH-1:0] out_data;

    logic signed [48:0]   smp_ext;
    logic signed [48:0]   lvl_ext;
    logic signed [48:0]   product;
    logic                 unused_top;
    logic [ENV_WIDTH-1:0] unused_lo;
    logic [ENV_WIDTH-1:0] scaled;

    // Whole pipeline advances together; a stalled output freezes everything.
    assign en            = !out_valid || data_out.ready;
    assign data_in.ready = en;
    assign beat          = data_in.valid && en;

    assign data_out.valid = out_valid;
    assign data_out.data  = out_data;

    // Signed sample times non-negative level; keep bits [47:24] (floor).
    assign smp_ext = {{25{s1_sample[ENV_WIDTH-1]}}, s1_sample};
    assign lvl_ext = {25'b0, s1_level};
    assign product = smp_ext * lvl_ext;
    assign {unused_top, scaled, unused_lo} = product;

    adsr_level u_level (
        .clk           (clk),
        .reset         (reset),
        .beat          (beat),
        .gate          (gate),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .level         (level),
        .state         (state),
        .env_active    (env_active)
    );

    // Stage 1: capture the sample with the level held before this beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sample <= '0;
            s1_level  <= '0;
        end else if (en) begin
            s1_valid <= beat;
            if (beat) begin
                s1_sample <= data_in.data;
                s1_level  <= level;
            end
        end
    end

    // Stage 2: register the scaled product; data holds between beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= scaled;
            end
        end
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// Self-checking bench for adsr_envelope: directed scenarios plus a
// randomized run against a per-beat behavioural model of the envelope.
module tb_adsr_envelope;
    import synth_pkg::*;

`ifdef ADSR_RETRIGGER_LEGATO_EN
    localparam bit LEGATO = 1'b1;
`else
    localparam bit LEGATO = 1'b0;
`endif

    localparam int M_IDLE = 0;
    localparam int M_ATT  = 1;
    localparam int M_DEC  = 2;
    localparam int M_SUS  = 3;
    localparam int M_REL  = 4;
    localparam longint MAXL = 64'hFFFFFF;

    logic        clk;
    logic        reset;
    logic        gate;
    logic [23:0] att, dec, sus, rel;
    logic        env_active;

    Axis_If in_if();
    Axis_If out_if();

    adsr_envelope dut (
        .clk           (clk),
        .reset         (reset),
        .gate          (gate),
        .attack_step   (att),
        .decay_step    (dec),
        .sustain_level (sus),
        .release_step  (rel),
        .data_in       (in_if),
        .data_out      (out_if),
        .env_active    (env_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    int     m_st;
    longint m_lvl;
    logic [23:0] exp_q[$];
    logic [23:0] got_q[$];

    function automatic logic [23:0] ref_out(logic [23:0] s, longint l);
        longint p;
        logic [63:0] r;
        p = longint'($signed(s)) * l;
        r = 64'(p >>> 24);
        return r[23:0];
    endfunction

    // One accepted beat of the envelope, written from the behaviour rules.
    function automatic void ref_beat(logic g);
        longint t;
        case (m_st)
            M_IDLE: begin
                m_lvl = 0;
                if (g) m_st = M_ATT;
            end
            M_ATT: begin
                if (!g) m_st = M_REL;
                else begin
                    t = m_lvl + longint'(att);
                    if (t >= MAXL) begin m_lvl = MAXL; m_st = M_DEC; end
                    else m_lvl = t;
                end
            end
            M_DEC: begin
                if (!g) m_st = M_REL;
                else begin
                    t = m_lvl - longint'(dec);
                    if (t <= longint'(sus)) begin
                        m_lvl = longint'(sus);
                        m_st  = M_SUS;
                    end else m_lvl = t;
                end
            end
            M_SUS: begin
                if (!g) m_st = M_REL;
                else m_lvl = longint'(sus);
            end
            default: begin
                if (g) begin
                    m_st = M_ATT;
                    if (!LEGATO) m_lvl = 0;
                end else begin
                    t = m_lvl - longint'(rel);
                    if (t <= 0) begin m_lvl = 0; m_st = M_IDLE; end
                    else m_lvl = t;
                end
            end
        endcase
    endfunction

    // Drive one clock of stimulus, record accepted and emitted beats.
    task automatic cycle(input logic g, input logic v,
                         input logic [23:0] s, input logic r);
        gate         = g;
        in_if.valid  = v;
        in_if.data   = s;
        out_if.ready = r;
        #4;
        if (in_if.valid && in_if.ready) begin
            exp_q.push_back(ref_out(s, m_lvl));
            ref_beat(g);
        end
        if (out_if.valid && out_if.ready)
            got_q.push_back(out_if.data);
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        repeat (4) cycle(gate, 1'b0, 24'h0, 1'b1);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        gate         = 1'b0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        m_st  = M_IDLE;
        m_lvl = 0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_if.valid !== 1'b0 || out_if.data !== 24'h0) begin
            n_bad++;
            $display("FAIL reset_out valid=%b data=%h need 0/000000",
                     out_if.valid, out_if.data);
        end
        n_cmp++;
        if (env_active !== 1'b0 || in_if.ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ctl env=%b rdy=%b need 0/1",
                     env_active, in_if.ready);
        end
        repeat (6) cycle(1'b0, 1'b1, 24'h400000, 1'b1);
        flush();
        n_cmp++;
        if (got_q.size() != 6) begin
            n_bad++;
            $display("FAIL reset_count got %0d need 6", got_q.size());
        end
        foreach (got_q[i]) begin
            n_cmp++;
            if (got_q[i] !== 24'h0) begin
                n_bad++;
                $display("FAIL reset_data[%0d] got %h need 000000",
                         i, got_q[i]);
            end
        end
        n_cmp++;
        if (env_active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_env got %b need 0", env_active);
        end
        att = 24'h100000;
        repeat (2) cycle(1'b1, 1'b1, 24'h7FFFFF, 1'b1);
        do_reset();
        flush();
        n_cmp++;
        if (got_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_discard got %0d beats need 0",
                     got_q.size());
        end
        n_cmp++;
        if (dut.u_level.state !== IDLE || env_active !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got %0d/%b need IDLE/0",
                     dut.u_level.state, env_active);
        end
    endtask

    task automatic test_attack();
        logic [23:0] ae [6];
        ae = '{24'h0, 24'h0, 24'h100000, 24'h200000, 24'h300000, 24'h3FFFFF};
        do_reset();
        att = 24'h400000;
        dec = 24'h0;
        sus = 24'h0;
        rel = 24'h0;
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b1, 24'h400000, 1'b1);
            if (i == 4) begin
                n_cmp++;
                if (dut.u_level.state !== DECAY) begin
                    n_bad++;
                    $display("FAIL attack_state got %0d need DECAY",
                             dut.u_level.state);
                end
            end
        end
        flush();
        n_cmp++;
        if (got_q.size() != 6) begin
            n_bad++;
            $display("FAIL attack_count got %0d need 6", got_q.size());
        end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== ae[i] || got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL attack_data[%0d] got %h need %h/%h",
                         i, got_q[i], ae[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_decay_sustain();
        logic [23:0] dl [4];
        dl = '{24'hDFFFFF, 24'hBFFFFF, 24'h9FFFFF, 24'h800000};
        dec = 24'h200000;
        sus = 24'h800000;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 24'hC00000, 1'b1);
            n_cmp++;
            if (dut.u_level.level !== dl[i]) begin
                n_bad++;
                $display("FAIL decay_level[%0d] got %h need %h",
                         i, dut.u_level.level, dl[i]);
            end
        end
        n_cmp++;
        if (dut.u_level.state !== SUSTAIN) begin
            n_bad++;
            $display("FAIL decay_state got %0d need SUSTAIN",
                     dut.u_level.state);
        end
        flush();
        n_cmp++;
        if (got_q.size() != 4 || got_q[0] !== 24'hC00000) begin
            n_bad++;
            $display("FAIL decay_first got n=%0d d=%h need 4/c00000",
                     got_q.size(), got_q.size() ? got_q[0] : 24'h0);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL decay_data[%0d] got %h need %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_release();
        logic [23:0] rl [3];
        rl = '{24'h800000, 24'h400000, 24'h000000};
        rel = 24'h400000;
        n_cmp++;
        if (env_active !== 1'b1) begin
            n_bad++;
            $display("FAIL release_env_pre got %b need 1", env_active);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 24'($urandom), 1'b1);
            n_cmp++;
            if (dut.u_level.level !== rl[i]) begin
                n_bad++;
                $display("FAIL release_level[%0d] got %h need %h",
                         i, dut.u_level.level, rl[i]);
            end
        end
        n_cmp++;
        if (dut.u_level.state !== IDLE || env_active !== 1'b0) begin
            n_bad++;
            $display("FAIL release_end got %0d/%b need IDLE/0",
                     dut.u_level.state, env_active);
        end
        flush();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL release_count got %0d need %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL release_data[%0d] got %h need %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        logic [23:0] d0, l0;
        do_reset();
        att = 24'h100000;
        dec = 24'h010000;
        sus = 24'h400000;
        rel = 24'h080000;
        repeat (4) cycle(1'b1, 1'b1, 24'($urandom), 1'b1);
        d0 = out_if.data;
        l0 = dut.u_level.level;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 24'($urandom), 1'b0);
            n_cmp++;
            if (in_if.ready !== 1'b0 || out_if.valid !== 1'b1 ||
                out_if.data !== d0 || dut.u_level.level !== l0) begin
                n_bad++;
                $display("FAIL stall[%0d] rdy=%b v=%b d=%h l=%h need 0/1/%h/%h",
                         i, in_if.ready, out_if.valid, out_if.data,
                         dut.u_level.level, d0, l0);
            end
        end
        repeat (4) cycle(1'b1, 1'b1, 24'($urandom), 1'b1);
        flush();
        n_cmp++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            n_bad++;
            $display("FAIL bp_count got %0d need 8 (model %0d)",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL bp_data[%0d] got %h need %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_retrigger();
        logic [23:0] l1, l2;
        l1 = LEGATO ? 24'h400000 : 24'h000000;
        l2 = LEGATO ? 24'h800000 : 24'h400000;
        do_reset();
        att = 24'h400000;
        dec = 24'h0;
        sus = 24'h0;
        rel = 24'h100000;
        repeat (2) cycle(1'b1, 1'b1, 24'h200000, 1'b1);
        cycle(1'b0, 1'b1, 24'h200000, 1'b1);
        n_cmp++;
        if (dut.u_level.state !== RELEASE ||
            dut.u_level.level !== 24'h400000) begin
            n_bad++;
            $display("FAIL retrig_pre got %0d/%h need RELEASE/400000",
                     dut.u_level.state, dut.u_level.level);
        end
        cycle(1'b1, 1'b1, 24'h200000, 1'b1);
        n_cmp++;
        if (dut.u_level.state !== ATTACK || dut.u_level.level !== l1) begin
            n_bad++;
            $display("FAIL retrig_beat got %0d/%h need ATTACK/%h",
                     dut.u_level.state, dut.u_level.level, l1);
        end
        cycle(1'b1, 1'b1, 24'h200000, 1'b1);
        n_cmp++;
        if (dut.u_level.level !== l2) begin
            n_bad++;
            $display("FAIL retrig_next got %h need %h",
                     dut.u_level.level, l2);
        end
        flush();
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL retrig_data[%0d] got %h need %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        logic g;
        do_reset();
        g = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 250 == 0) begin
                att = 24'($urandom_range(0, 32'hFFFFFF) >> $urandom_range(0, 12));
                dec = 24'($urandom_range(0, 32'hFFFFFF) >> $urandom_range(0, 12));
                rel = 24'($urandom_range(0, 32'hFFFFFF) >> $urandom_range(0, 12));
                sus = 24'($urandom);
                if ($urandom_range(0, 7) == 0) dec = 24'h0;
            end
            if ($urandom_range(0, 39) == 0) g = ~g;
            cycle(g, $urandom_range(0, 3) != 0, 24'($urandom),
                  $urandom_range(0, 3) != 0);
        end
        flush();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_bad++;
            $display("FAIL rand_count got %0d need %0d",
                     got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_bad++;
                $display("FAIL rand_data[%0d] got %h need %h",
                         i, got_q[i], exp_q[i]);
            end
        end
        n_cmp++;
        if (longint'(dut.u_level.level) != m_lvl ||
            env_active !== (m_st != M_IDLE)) begin
            n_bad++;
            $display("FAIL rand_end got %h/%b need %h/%b",
                     dut.u_level.level, env_active, m_lvl[23:0],
                     m_st != M_IDLE);
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        reset        = 1'b1;
        gate         = 1'b0;
        att          = '0;
        dec          = '0;
        sus          = '0;
        rel          = '0;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        m_st         = M_IDLE;
        m_lvl        = 0;
        test_reset();
        test_attack();
        test_decay_sustain();
        test_release();
        test_backpressure();
        test_retrigger();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
